// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU operation sequencer.
//   state_e : issue FSM states
//   SEL_*   : ALU select encodings
//   cmd_t   : one queued command {acc, sel, c, b, a}
// The command operand width is fixed by CMD_WIDTH. To change the sequencer
// WIDTH, change CMD_WIDTH here as well.
package alu_seq_pkg;

  localparam int CMD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] SEL_ADD  = 2'b00;
  localparam logic [1:0] SEL_SUB  = 2'b01;
  localparam logic [1:0] SEL_MUL  = 2'b10;
  localparam logic [1:0] SEL_ONES = 2'b11;

  typedef struct packed {
    logic                 acc;
    logic [1:0]           sel;
    logic                 c;
    logic [CMD_WIDTH-1:0] b;
    logic [CMD_WIDTH-1:0] a;
  } cmd_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and result handshakes of the ALU operation sequencer.
//   in_*      : command valid/ready channel with operands and options
//   res_*     : result valid/ready channel with data and flag
// The master modport is the command producer and result consumer.
// The slave modport is the sequencer.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_c;
  logic [1:0]         in_sel;
  logic               in_acc;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] res_data;
  logic               res_flag;

  modport master (
    output in_valid, in_a, in_b, in_c, in_sel, in_acc, res_ready,
    input  in_ready, res_valid, res_data, res_flag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_sel, in_acc, res_ready,
    output in_ready, res_valid, res_data, res_flag
  );
endinterface

// File: rtl/alu_op_sequencer_cmd_fifo.sv
// Synchronous command FIFO for the ALU operation sequencer.
//   clk, rst_n : clock and async active-low reset (reset empties the queue)
//   push/wr_cmd: write a command (ignored when full)
//   pop/rd_cmd : rd_cmd is the head entry; pop removes it (ignored when empty)
//   full/empty : derived from the occupancy count
// FIFO_DEPTH must be a power of two so that the pointers wrap naturally.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t wr_cmd,
  input  logic pop,
  output cmd_t rd_cmd,
  output logic full,
  output logic empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  cmd_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_cmd  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_cmd;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the combinational byte ALU.
//   clk, rst_n   : clock and async active-low reset
//   bus (slave)  : command channel in_* and result channel res_*
//   alu_a/b/c/sel: registered operands and select driven to the ALU
//   alu_out/flag : ALU result and carry/borrow flag returned to the sequencer
//   sticky_flag  : OR of every captured flag since reset or the last flag_clr
//   flag_clr     : synchronous clear of sticky_flag
// Commands are queued, issued one at a time, and given one EXEC cycle for
// the ALU to settle. The result is then captured and held until it is
// consumed. With in_acc set, a command takes the low half of the previous
// result as operand A.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = CMD_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_op_sequencer_if.slave    bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_c,
  output logic [1:0]           alu_sel,
  input  logic [2*WIDTH-1:0]   alu_out,
  input  logic                 alu_flag,
  output logic                 sticky_flag,
  input  logic                 flag_clr
);
  state_e             state_q;
  state_e             state_d;
  logic               issue;
  logic               capture;
  logic               fifo_full;
  logic               fifo_empty;
  cmd_t               wr_cmd;
  cmd_t               head_cmd;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] res_data_q;
  logic               res_flag_q;

  assign wr_cmd = '{acc: bus.in_acc, sel: bus.in_sel, c: bus.in_c,
                    b: bus.in_b, a: bus.in_a};

  // in_ready deliberately ignores a same-cycle pop.
  assign bus.in_ready  = !fifo_full;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_flag  = res_flag_q;

  alu_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (bus.in_valid),
    .wr_cmd (wr_cmd),
    .pop    (issue),
    .rd_cmd (head_cmd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          issue   = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          if (!fifo_empty) begin
            issue   = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_c       <= 1'b0;
      alu_sel     <= SEL_ADD;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_flag_q  <= 1'b0;
      sticky_flag <= 1'b0;
    end else begin
      state_q <= state_d;
      // acc_q already holds the previous result here because only one
      // command is ever in flight.
      if (issue) begin
        alu_a   <= head_cmd.acc ? acc_q[WIDTH-1:0] : head_cmd.a;
        alu_b   <= head_cmd.b;
        alu_c   <= head_cmd.c;
        alu_sel <= head_cmd.sel;
      end
      if (capture) begin
        res_data_q <= alu_out;
        res_flag_q <= alu_flag;
        acc_q      <= alu_out;
      end
      // A clear wins over a flag captured on the same edge.
      if (flag_clr)
        sticky_flag <= 1'b0;
      else if (capture)
        sticky_flag <= sticky_flag | alu_flag;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(W)) bus ();

  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic           alu_c;
  logic [1:0]     alu_sel;
  logic [2*W-1:0] alu_out;
  logic           alu_flag;
  logic           sticky_flag;
  logic           flag_clr;

  alu_op_sequencer #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_c       (alu_c),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_flag    (alu_flag),
    .sticky_flag (sticky_flag),
    .flag_clr    (flag_clr)
  );

  // Behavioural byte ALU returning the result to the sequencer
  logic [W:0] alu_tmp;
  always_comb begin
    alu_out  = '0;
    alu_flag = 1'b0;
    alu_tmp  = '0;
    case (alu_sel)
      2'b00: begin
        alu_tmp  = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_c};
        alu_out  = {{W{1'b0}}, alu_tmp[W-1:0]};
        alu_flag = alu_tmp[W];
      end
      2'b01: begin
        alu_tmp  = {1'b0, alu_a} - {1'b0, alu_b} - {{W{1'b0}}, alu_c};
        alu_out  = {{W{1'b0}}, alu_tmp[W-1:0]};
        alu_flag = alu_tmp[W];
      end
      2'b10: alu_out = alu_a * alu_b;
      default: alu_out = '1;
    endcase
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [1:0] sel, input logic acc);
    int t;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_c     = c;
    bus.in_sel   = sel;
    bus.in_acc   = acc;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("send_ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(output int waited);
    waited = 0;
    while (!bus.res_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("res_valid_seen", {31'b0, bus.res_valid}, 32'd1);
  endtask

  task automatic take();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        c;
    logic [1:0]  sel;
    logic        acc;
    logic [15:0] exp_data;
    logic        exp_flag;
    logic        exp_sticky;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int w;
    int accepted;
    logic [15:0] expq [$];

    vecs[0]  = '{8'hFF, 8'h01, 1'b0, SEL_ADD,  1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{8'hFF, 8'hFF, 1'b0, SEL_MUL,  1'b0, 16'hFE01, 1'b0, 1'b1};
    vecs[2]  = '{8'h12, 8'h34, 1'b0, SEL_ONES, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    vecs[3]  = '{8'h10, 8'h20, 1'b0, SEL_ADD,  1'b0, 16'h0030, 1'b0, 1'b1};
    vecs[4]  = '{8'hAA, 8'h05, 1'b0, SEL_ADD,  1'b1, 16'h0035, 1'b0, 1'b1};
    vecs[5]  = '{8'h05, 8'h03, 1'b1, SEL_SUB,  1'b0, 16'h0001, 1'b0, 1'b1};
    vecs[6]  = '{8'h03, 8'h05, 1'b0, SEL_SUB,  1'b0, 16'h00FE, 1'b1, 1'b1};
    vecs[7]  = '{8'h00, 8'h02, 1'b1, SEL_ADD,  1'b1, 16'h0001, 1'b1, 1'b1};
    vecs[8]  = '{8'h00, 8'h7F, 1'b0, SEL_MUL,  1'b1, 16'h007F, 1'b0, 1'b1};
    vecs[9]  = '{8'h80, 8'h80, 1'b1, SEL_ADD,  1'b0, 16'h0001, 1'b1, 1'b1};
    vecs[10] = '{8'h00, 8'h00, 1'b0, SEL_ONES, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    vecs[11] = '{8'h55, 8'h00, 1'b0, SEL_ADD,  1'b1, 16'h00FF, 1'b0, 1'b1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = 1'b0;
    bus.in_sel    = 2'b00;
    bus.in_acc    = 1'b0;
    bus.res_ready = 1'b0;
    flag_clr      = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    check("rst_res_data",  {16'b0, bus.res_data},  32'd0);
    check("rst_alu_a",     {24'b0, alu_a},         32'd0);
    check("rst_sticky",    {31'b0, sticky_flag},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: push at edge N, result visible after edge N+2
    bus.res_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'h10;
    bus.in_b      = 8'h20;
    bus.in_c      = 1'b0;
    bus.in_sel    = SEL_ADD;
    bus.in_acc    = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("lat_n",   {31'b0, bus.res_valid}, 32'd0);
    @(negedge clk);
    check("lat_n1",  {31'b0, bus.res_valid}, 32'd0);
    @(negedge clk);
    check("lat_n2",  {31'b0, bus.res_valid}, 32'd1);
    check("lat_data", {16'b0, bus.res_data}, 32'h0030);
    check("lat_flag", {31'b0, bus.res_flag}, 32'd0);
    @(negedge clk);
    bus.res_ready = 1'b0;

    // Table-driven single commands
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sel, vecs[i].acc);
      wait_res(w);
      check($sformatf("vec%0d_data", i),   {16'b0, bus.res_data},  {16'b0, vecs[i].exp_data});
      check($sformatf("vec%0d_flag", i),   {31'b0, bus.res_flag},  {31'b0, vecs[i].exp_flag});
      check($sformatf("vec%0d_sticky", i), {31'b0, sticky_flag},   {31'b0, vecs[i].exp_sticky});
      take();
    end

    // flag_clr clears sticky, result register untouched
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("clr_sticky", {31'b0, sticky_flag},  32'd0);
    check("clr_data",   {16'b0, bus.res_data}, 32'h00FF);

    // flag_clr wins over a same-edge flag capture
    flag_clr = 1'b1;
    send(8'hFF, 8'h01, 1'b0, SEL_ADD, 1'b0);
    wait_res(w);
    check("prio_res_flag", {31'b0, bus.res_flag}, 32'd1);
    check("prio_sticky",   {31'b0, sticky_flag},  32'd0);
    flag_clr = 1'b0;
    take();

    // Backpressure: hold in_valid 10 cycles with res_ready low
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 8'(i);
      bus.in_b     = 8'(8'h40 + i);
      bus.in_c     = 1'b0;
      bus.in_sel   = SEL_ADD;
      bus.in_acc   = 1'b0;
      if (bus.in_ready) begin
        accepted++;
        expq.push_back(16'(8'h40 + 2 * i));
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("bp_accepted",  accepted, 32'd5);
    check("bp_in_ready",  {31'b0, bus.in_ready},  32'd0);
    check("bp_res_valid", {31'b0, bus.res_valid}, 32'd1);
    check("bp_res_hold",  {16'b0, bus.res_data},  32'h0040);
    bus.res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_res(w);
      if (k > 0) check($sformatf("drain%0d_gap", k), w, 32'd1);
      if (k < expq.size())
        check($sformatf("drain%0d_data", k), {16'b0, bus.res_data}, {16'b0, expq[k]});
      @(negedge clk);
    end
    bus.res_ready = 1'b0;
    check("drain_empty_valid", {31'b0, bus.res_valid}, 32'd0);
    check("drain_in_ready",    {31'b0, bus.in_ready},  32'd1);

    // Simultaneous push and pop at FIFO_DEPTH-1 entries
    for (int k = 0; k < 4; k++) send(8'h01, 8'(8'h50 + k), 1'b0, SEL_ADD, 1'b0);
    check("pp_head_data", {16'b0, bus.res_data}, 32'h0051);
    check("pp_pre_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'h01;
    bus.in_b      = 8'h54;
    bus.in_sel    = SEL_ADD;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pp_post_ready", {31'b0, bus.in_ready}, 32'd1);
    for (int k = 1; k < 5; k++) begin
      wait_res(w);
      check($sformatf("pp%0d_data", k), {16'b0, bus.res_data}, 32'(16'h0051 + k));
      @(negedge clk);
    end
    bus.res_ready = 1'b0;
    check("pp_done_valid", {31'b0, bus.res_valid}, 32'd0);

    // Reset during EXEC with 3 commands still queued
    send(8'hFF, 8'h02, 1'b0, SEL_ADD, 1'b0);
    for (int k = 0; k < 4; k++) send(8'h01, 8'(8'h60 + k), 1'b0, SEL_ADD, 1'b0);
    check("mr_pre_data",   {16'b0, bus.res_data}, 32'h0001);
    check("mr_pre_sticky", {31'b0, sticky_flag},  32'd1);
    check("mr_pre_full",   {31'b0, bus.in_ready}, 32'd0);
    take();
    check("mr_in_exec", {31'b0, bus.res_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mr_res_valid", {31'b0, bus.res_valid}, 32'd0);
    check("mr_res_data",  {16'b0, bus.res_data},  32'd0);
    check("mr_res_flag",  {31'b0, bus.res_flag},  32'd0);
    check("mr_sticky",    {31'b0, sticky_flag},   32'd0);
    check("mr_alu_a",     {24'b0, alu_a},         32'd0);
    check("mr_alu_b",     {24'b0, alu_b},         32'd0);
    check("mr_in_ready",  {31'b0, bus.in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("mr_stale%0d", k), {31'b0, bus.res_valid}, 32'd0);
    end
    check("mr_post_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.res_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream issue stage for the byte ALU. It accepts operation commands through a valid/ready handshake and queues them in a small FIFO. It drives registered operands, carry and select to the combinational ALU, then captures ALU_out/flag into a result register with its own valid/ready handshake. An accumulator mode lets a command use the low byte of the previous result as operand A, so chained arithmetic needs no round trip.

Parameters:
WIDTH, 8, operand width; result width is 2*WIDTH.
FIFO_DEPTH, 4, command queue entries; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  command present.
in_ready  out  1  command FIFO can accept; equals not-full.
in_a  in  WIDTH  operand A; ignored when in_acc=1.
in_b  in  WIDTH  operand B.
in_c  in  1  carry/borrow in for add/sub.
in_sel  in  2  00 add, 01 sub, 10 mul, 11 constant all-ones.
in_acc  in  1  use acc[WIDTH-1:0] as operand A.
alu_a  out  WIDTH  registered operand A to ALU.
alu_b  out  WIDTH  registered operand B to ALU.
alu_c  out  1  registered carry to ALU.
alu_sel  out  2  registered select to ALU.
alu_out  in  2*WIDTH  ALU result.
alu_flag  in  1  ALU carry/borrow flag.
res_valid  out  1  result available.
res_ready  in  1  consumer takes result.
res_data  out  2*WIDTH  captured result.
res_flag  out  1  captured flag.
sticky_flag  out  1  OR of all captured flags since reset or clear.
flag_clr  in  1  synchronous clear of sticky_flag.

Behaviour:
- Reset (async, rst_n low): FIFO empty, state IDLE, alu_a/alu_b/alu_c/alu_sel = 0, res_data = 0, res_flag = 0, res_valid = 0, acc = 0, sticky_flag = 0. in_ready = 1 during and after reset (FIFO empty).
- A reset mid-operation discards all queued and in-flight commands. No result is emitted for them.
- Push when in_valid & in_ready. Pop when the FSM issues. Push and pop on the same edge are legal at any fill level. in_ready does not look ahead to a same-cycle pop, so a full FIFO deasserts in_ready.
- States:
  - IDLE: if the FIFO is non-empty, pop on this edge, load the alu_* registers and go to EXEC.
  - EXEC: one cycle while the ALU settles. On the edge leaving EXEC:
    - res_data <= alu_out, res_flag <= alu_flag, res_valid <= 1;
    - acc <= alu_out;
    - sticky_flag |= alu_flag;
    - go to DONE.
  - DONE: res_valid = 1. res_data and res_flag stay stable until res_ready.
    - On res_ready: res_valid <= 0. If the FIFO is non-empty, pop and load the alu_* registers on the same edge and go to EXEC; otherwise go to IDLE.
- Latency: a command accepted into an empty FIFO in IDLE at edge N is popped at edge N+1, issued, and captured at edge N+2, so res_valid is high after edge N+2. Peak throughput is one result per 2 cycles.
- Operand A at issue: in_acc=1 selects acc[WIDTH-1:0] as it stands at the issue edge. This is always the previous captured result, because only one command is in flight.
- Widths: acc stores the full 2*WIDTH result, but only the low WIDTH bits feed back. The high byte of a multiply is dropped in chaining. sel 11 gives acc low byte 0xFF.
- flag_clr has priority over a same-edge flag capture: sticky_flag <= 0.
- alu_* registers hold their last value between commands; they are not cleared on completion.
- Order is strictly FIFO. No command is dropped or reordered.

Decomposition:
- Package alu_seq_pkg:
  - state enum {IDLE, EXEC, DONE};
  - sel constants SEL_ADD=2'b00, SEL_SUB=2'b01, SEL_MUL=2'b10, SEL_ONES=2'b11;
  - packed command struct {acc, sel, c, b, a}.
- Sub-module alu_cmd_fifo: synchronous FIFO of command structs, parameterised by FIFO_DEPTH, with full/empty from a count register. Same clk and rst_n; async reset empties it.
- The ALU itself is not instantiated here. The enclosing top wires alu_* to A/B/c/sel and returns ALU_out/flag.

Test Plan:
- Add: in_a=0x10, in_b=0x20, in_c=0, sel=00 accepted at edge N with res_ready=1 -> res_valid after edge N+2; res_data=0x0030, res_flag=0.
- Carry and sticky: add 0xFF+0x01, c=0 -> res_data=0x0000, res_flag=1, sticky_flag=1. Then pulse flag_clr -> sticky_flag=0 while res_data is unchanged.
- Multiply, constant and chaining:
  - mul 0xFF*0xFF -> 0xFE01, flag 0.
  - sel=11 -> 0xFFFF.
  - add 0x10+0x20, then in_acc=1 add B=0x05 -> second res_data=0x0035.
- Backpressure: res_ready=0, in_valid held 10 cycles with distinct B values -> exactly 1+FIFO_DEPTH=5 accepted, in_ready low after that. res_data stays stable. Raising res_ready drains 5 results in order, one per 2 cycles.
- Reset mid-op: assert rst_n=0 during EXEC with 3 commands queued -> all outputs at reset values immediately. After release, no stale result appears and in_ready=1.
- Simultaneous push and pop: FIFO at FIFO_DEPTH-1 entries, push on the same edge DONE pops -> count unchanged, no overflow, ordering preserved.
